time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven editor for the clock time and alarm.
// Edits a BCD HH:MM:SS buffer digit by digit and commits it with a strobe.
module time_set_ctrl #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic        time_set_ctrl_clk,
  input  logic        time_set_ctrl_rst_n,
  input  logic        time_set_ctrl_tick,
  input  logic        time_set_ctrl_mode,
  input  logic        time_set_ctrl_confirm,
  input  logic        time_set_ctrl_left,
  input  logic        time_set_ctrl_right,
  input  logic        time_set_ctrl_up,
  input  logic        time_set_ctrl_down,
  input  logic [23:0] time_set_ctrl_time_in,
  input  logic [23:0] time_set_ctrl_alarm_in,
  output logic [23:0] time_set_ctrl_edit_val,
  output logic [5:0]  time_set_ctrl_cursor,
  output logic        time_set_ctrl_time_load,
  output logic        time_set_ctrl_alarm_load,
  output logic [1:0]  time_set_ctrl_state
);

  localparam int CW =
    (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    EDIT_TIME  = 2'b01,
    EDIT_ALARM = 2'b10,
    COMMIT     = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   edit_q, edit_d;
  logic [5:0]    cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          src_time_q, src_time_d;

  logic [5:0]    press;
  logic [5:0]    grant;
  logic [3:0]    dsel;
  logic [3:0]    dmax;
  logic [3:0]    up_val;
  logic [3:0]    dn_val;
  logic [23:0]   edit_up;
  logic [23:0]   edit_dn;

  // Lowest set bit wins: bit 0 is mode, the highest priority button.
  assign press = {time_set_ctrl_down,
                  time_set_ctrl_up,
                  time_set_ctrl_right,
                  time_set_ctrl_left,
                  time_set_ctrl_confirm,
                  time_set_ctrl_mode};
  assign grant = press & (~press + 6'd1);

  always_comb begin
    dsel = 4'd0;
    for (int i = 0; i < 6; i++)
      if (cur_q[i]) dsel = edit_q[4*i +: 4];
  end

  always_comb begin
    unique case (1'b1)
      cur_q[0], cur_q[2]: dmax = 4'd9;
      cur_q[1], cur_q[3]: dmax = 4'd5;
      cur_q[4]:
        dmax = (edit_q[23:20] == 4'd2) ? 4'd3 : 4'd9;
      default: dmax = 4'd2;
    endcase
  end

  // Digits above their maximum (loaded illegal BCD) snap to zero.
  always_comb begin
    up_val = (dsel >= dmax) ? 4'd0 : dsel + 4'd1;
    if (dsel > dmax)
      dn_val = 4'd0;
    else if (dsel == 4'd0)
      dn_val = dmax;
    else
      dn_val = dsel - 4'd1;
  end

  always_comb begin
    edit_up = edit_q;
    edit_dn = edit_q;
    for (int i = 0; i < 6; i++) begin
      if (cur_q[i]) begin
        edit_up[4*i +: 4] = up_val;
        edit_dn[4*i +: 4] = dn_val;
      end
    end
    if (cur_q[5] && up_val == 4'd2 &&
        edit_q[19:16] > 4'd3)
      edit_up[19:16] = 4'd3;
    if (cur_q[5] && dn_val == 4'd2 &&
        edit_q[19:16] > 4'd3)
      edit_dn[19:16] = 4'd3;
  end

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    src_time_d = src_time_q;
    unique case (state_q)
      IDLE: begin
        cur_d = 6'b000000;
        cnt_d = '0;
        if (time_set_ctrl_mode) begin
          state_d = EDIT_TIME;
          edit_d  = time_set_ctrl_time_in;
          cur_d   = 6'b000001;
        end
      end
      EDIT_TIME, EDIT_ALARM: begin
        if (|press) cnt_d = '0;
        unique case (1'b1)
          grant[0]: begin
            if (state_q == EDIT_TIME) begin
              state_d = EDIT_ALARM;
              edit_d  = time_set_ctrl_alarm_in;
              cur_d   = 6'b000001;
            end else begin
              state_d = IDLE;
              cur_d   = 6'b000000;
            end
          end
          grant[1]: begin
            state_d    = COMMIT;
            src_time_d = (state_q == EDIT_TIME);
          end
          grant[2]: cur_d = {cur_q[4:0], cur_q[5]};
          grant[3]: cur_d = {cur_q[0], cur_q[5:1]};
          grant[4]: edit_d = edit_up;
          grant[5]: edit_d = edit_dn;
          default: begin
            if (time_set_ctrl_tick) begin
              if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cur_d   = 6'b000000;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        cur_d   = 6'b000000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge time_set_ctrl_clk or
              negedge time_set_ctrl_rst_n) begin
    if (!time_set_ctrl_rst_n) begin
      state_q    <= IDLE;
      edit_q     <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      src_time_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edit_q     <= edit_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      src_time_q <= src_time_d;
    end
  end

  assign time_set_ctrl_edit_val   = edit_q;
  assign time_set_ctrl_cursor     = cur_q;
  assign time_set_ctrl_state      = state_q;
  assign time_set_ctrl_time_load  =
    (state_q == COMMIT) && src_time_q;
  assign time_set_ctrl_alarm_load =
    (state_q == COMMIT) && !src_time_q;

endmodule
